mux4a1_arbiter: RTL and testbench
=================================

# mux4a1_arbiter

Round-robin arbiter and select sequencer for the 4:1 single-bit multiplexer (`mux4a1`). Four requesters compete for the shared mux output. The arbiter grants one at a time and drives the mux select lines `S1`,`S0` with the registered index of the current owner. A programmable hold limit bounds how long one requester can keep the mux while others wait.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one owner while another request is pending. Legal range 1..15.
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  request vector; `req[i]` means requester i wants mux input `Di`.
- `gnt`  out  4  one-hot grant, registered; all zeros when idle.
- `S0`  out  1  mux select LSB, registered; equals bit 0 of the owner index.
- `S1`  out  1  mux select MSB, registered; equals bit 1 of the owner index.
- `busy`  out  1  high while any grant is active (`|gnt`).

## Operation
- Two states:
  - `IDLE`: no owner.
  - `GRANT`: owner index `own[1:0]` is valid.
- Registered `ptr[1:0]` holds the last granted index. The round-robin search order starts at `ptr+1` and wraps modulo 4 (3 → 0).
- 4-bit hold counter `hcnt`:
  - Cleared to 0 on every new grant.
  - Increments each cycle the same owner is retained.
  - Saturates at `MAX_HOLD-1`.
- `IDLE`, `req==0`: stay in `IDLE`.
- `IDLE`, `req!=0`: grant the first set bit in search order. Go to `GRANT`, set `own` and `ptr` to that index, clear `hcnt`.
- `GRANT`, `req[own]==0`, other requests pending: hand over in the same edge to the next requester in search order from `own+1`. There is no idle bubble.
- `GRANT`, `req[own]==0`, no other requests: go to `IDLE`, `gnt`=0000, `busy`=0. `S1`,`S0` keep their last value.
- `GRANT`, `req[own]==1`, `hcnt==MAX_HOLD-1`, another request pending: forced rotation to the next requester in search order from `own+1`.
- `GRANT`, `req[own]==1`, otherwise: keep `own`. A lone requester keeps the grant indefinitely.
- Invariants:
  - `gnt` is always one-hot or zero.
  - `{S1,S0}==own` whenever `busy`=1.
  - `S1`,`S0`,`gnt` and `busy` change only on the same edge.
- Reset values: `gnt`=0000, `S0`=0, `S1`=0, `busy`=0, state `IDLE`, `hcnt`=0, `ptr`=3. With `ptr`=3 the first search after reset starts at index 0.
- Reset asserted mid-grant: all outputs and state go to reset values immediately, without waiting for a clock edge. An in-flight grant is dropped.
- `MAX_HOLD`=1: an owner is rotated out after every cycle whenever another request is pending.

## Timing
- `req` is sampled on the rising edge of `clk`. Grant and select update on that same edge, so outputs are visible one cycle after a request is presented.
- Release latency: the owner deasserts `req` before edge n; `gnt` changes at edge n, either to the next owner or to 0000.
- With all four requesting continuously, each owner holds exactly `MAX_HOLD` cycles, in order 0,1,2,3,0,…
- Fairness: a requester that stays asserted is granted within 3·`MAX_HOLD`+1 cycles.
- Downstream mux path is combinational: `Q` reflects `D{own}` in the same cycle as `gnt`.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `req`=1111 → `gnt`=0000, `S1S0`=00, `busy`=0 on every cycle. Release `rst` → at the next edge `gnt`=0001, `S1S0`=00.
- Single requester: `req`=0100 for 3 cycles, then 0000 → `gnt`=0100, `S1S0`=10, `busy`=1 for 3 cycles. Then `gnt`=0000, `busy`=0, `S1S0` stays 10.
- Full contention, `MAX_HOLD`=4: `req`=1111 for 20 cycles → `gnt` sequence is 0001 ×4, 0010 ×4, 0100 ×4, 1000 ×4, 0001 ×4. `S1S0` follows 00,01,10,11,00. Drive `D0..D3`=1,0,1,0 and check `Q` = 1,0,1,0,1 per slot.
- Handover without bubble: owner 0 drops `req[0]` while `req`=1010 → next edge `gnt`=0010, `S1S0`=01, and `busy` never goes low.
- Lone holder: `req`=1000 for 12 cycles, `MAX_HOLD`=4 → `gnt`=1000 for all 12 cycles and `hcnt` saturates at 3. Raise `req[1]` → rotation to `gnt`=0010 at the next edge.
- Asynchronous reset mid-operation: during full contention with `gnt`=0100, assert `rst` between clock edges → `gnt`=0000, `S1S0`=00, `busy`=0 immediately. After release with `req`=1111 → first grant is 0001, confirming `ptr` was reset.

Source files
------------

// File: rtl/mux4a1_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 single-bit mux.
// One owner at a time; a hold limit forces rotation while others are waiting.
module mux4a1_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       S0,
  output logic       S1,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [1:0] own_reg, own_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] hcnt_reg, hcnt_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] sel_reg, sel_next;

  logic [3:0] cand;
  logic [3:0] rot;
  logic       found;
  logic [1:0] pick;

  // While granted the owner is excluded, so a hit means someone else is waiting.
  assign cand = (state_reg == GRANT) ? (req & ~(4'b0001 << own_reg)) : req;

  // rot[k] is the candidate at search position k, starting from ptr+1.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot[gi] = cand[ptr_reg + 2'(gi + 1)];
    end
  endgenerate

  assign found = |rot;

  always_comb begin
    pick = ptr_reg;
    for (int j = 3; j >= 0; j--) begin
      if (rot[j]) pick = ptr_reg + 2'(j + 1);
    end
  end

  always_comb begin
    state_next = state_reg;
    own_next   = own_reg;
    ptr_next   = ptr_reg;
    hcnt_next  = hcnt_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          own_next   = pick;
          ptr_next   = pick;
          hcnt_next  = 4'd0;
        end
      end
      GRANT: begin
        if (!req[own_reg]) begin
          if (found) begin
            own_next  = pick;
            ptr_next  = pick;
            hcnt_next = 4'd0;
          end else begin
            state_next = IDLE;
          end
        end else if (hcnt_reg == HOLD_LAST && found) begin
          own_next  = pick;
          ptr_next  = pick;
          hcnt_next = 4'd0;
        end else if (hcnt_reg != HOLD_LAST) begin
          hcnt_next = hcnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Select keeps its last value when idle so the mux output does not glitch.
  always_comb begin
    gnt_next = 4'b0000;
    sel_next = sel_reg;
    if (state_next == GRANT) begin
      gnt_next = 4'b0001 << own_next;
      sel_next = own_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      own_reg   <= 2'd0;
      ptr_reg   <= 2'd3;
      hcnt_reg  <= 4'd0;
      gnt_reg   <= 4'b0000;
      sel_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      own_reg   <= own_next;
      ptr_reg   <= ptr_next;
      hcnt_reg  <= hcnt_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
    end
  end

  assign gnt  = gnt_reg;
  assign S0   = sel_reg[0];
  assign S1   = sel_reg[1];
  assign busy = |gnt_reg;

endmodule

// File: tb/tb_mux4a1_arbiter.sv
// Scoreboard bench for mux4a1_arbiter: stimulus queues expected outputs,
// a monitor pops and compares one entry per clock (or async reset event).
module tb_mux4a1_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       S0, S1, busy;
  logic [3:0] d = 4'b0101;   // D0..D3 = 1,0,1,0
  logic       q;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       q;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  event async_ev;

  mux4a1_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt),
    .S0  (S0),
    .S1  (S1),
    .busy(busy)
  );

  // Downstream combinational mux
  assign q = d[{S1, S0}];

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] eg, input logic [1:0] es, input string tag);
    exp_t e;
    e.gnt  = eg;
    e.sel  = es;
    e.busy = |eg;
    e.q    = d[es];
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Called at a falling edge: drive inputs, queue the result of the next rising edge.
  task automatic cyc(input logic [3:0] r, input logic rv, input logic [3:0] eg,
                     input logic [1:0] es, input string tag);
    req = r;
    rst = rv;
    push(eg, es, tag);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (gnt === e.gnt && {S1, S0} === e.sel && busy === e.busy && q === e.q) begin
          passes++;
          $display("txn %0d %s: gnt=%b sel=%b busy=%b q=%b ok", checks, e.tag, gnt, {S1, S0}, busy, q);
        end else begin
          $display("FAIL txn %0d %s: got gnt=%b sel=%b busy=%b q=%b, expected gnt=%b sel=%b busy=%b q=%b",
                   checks, e.tag, gnt, {S1, S0}, busy, q, e.gnt, e.sel, e.busy, e.q);
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    req = 4'b1111;

    for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b1, 4'b0000, 2'd0, "reset");

    // Release into full contention: 4 cycles per owner, 0,1,2,3,0
    for (int i = 0; i < 20; i++) begin
      k = (i / 4) % 4;
      cyc(4'b1111, 1'b0, 4'(1 << k), 2'(k), "contend");
    end

    cyc(4'b1010, 1'b0, 4'b0010, 2'd1, "handover");
    for (int i = 0; i < 3; i++) cyc(4'b1010, 1'b0, 4'b0010, 2'd1, "hold1");
    cyc(4'b1010, 1'b0, 4'b1000, 2'd3, "rotate3");

    for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b0, 4'b0100, 2'd2, "single");
    for (int i = 0; i < 2; i++) cyc(4'b0000, 1'b0, 4'b0000, 2'd2, "idle");

    for (int i = 0; i < 12; i++) cyc(4'b1000, 1'b0, 4'b1000, 2'd3, "lone");
    cyc(4'b1010, 1'b0, 4'b0010, 2'd1, "lone_rot");

    for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b0, 4'b0010, 2'd1, "pre_rst");
    cyc(4'b1111, 1'b0, 4'b0100, 2'd2, "pre_rst");

    // Reset between edges while owner 2 holds the mux
    rst = 1'b1;
    push(4'b0000, 2'd0, "async_rst");
    ->async_ev;
    cyc(4'b1111, 1'b1, 4'b0000, 2'd0, "rst_hold");
    cyc(4'b1111, 1'b0, 4'b0001, 2'd0, "rst_rel");
    cyc(4'b1111, 1'b0, 4'b0001, 2'd0, "rst_rel");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
